// File: rtl/rocstar_mcu_rx.sv
// ROCSTAR receiver for the 4-bit MCU cable stream: IDLE-rotation lock, coincidence pulses, special words.
// Optional statistics counters are enabled by defining ROCSTAR_RX_STATS_EN.
module rocstar_mcu_rx #(
  parameter int LOCK_IDLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             stats_clr,
  output logic             locked,
  output logic             pcoinc,
  output logic             ncoinc,
  output logic             dcoinc,
  output logic             spw_valid,
  output logic [15:0]      spword,
  output logic             err,
  output logic [CNT_W-1:0] n_pcoin,
  output logic [CNT_W-1:0] n_ncoin,
  output logic [CNT_W-1:0] n_err
);

  localparam logic [3:0] SYM_NCOIN = 4'b1001;
  localparam logic [3:0] SYM_PCOIN = 4'b0011;
  localparam logic [3:0] SYM_DCOIN = 4'b0110;
  localparam logic [3:0] SYM_SPECL = 4'b1100;
  localparam logic [7:0] LOCK_N    = 8'(LOCK_IDLES);

  typedef enum logic [2:0] {HUNT, RUN, SP1, SP2, SP3, SP4} state_e;

  state_e      state_q, state_d;
  logic [3:0]  din_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  exp_q, exp_d;
  logic [11:0] shift_q, shift_d;
  logic [15:0] spword_q, spword_d;
  logic        locked_q, locked_d;
  logic        pcoinc_q, pcoinc_d, ncoinc_q, ncoinc_d, dcoinc_q, dcoinc_d;
  logic        spwValid_q, spwValid_d, err_q, err_d;
  logic        isIdle;
  logic [1:0]  idleIdx;

  always_comb begin
    isIdle  = 1'b1;
    idleIdx = 2'd0;
    case (din_q)
      4'b0111: idleIdx = 2'd0;
      4'b1011: idleIdx = 2'd1;
      4'b1101: idleIdx = 2'd2;
      4'b1110: idleIdx = 2'd3;
      default: isIdle  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    shift_d    = shift_q;
    spword_d   = spword_q;
    locked_d   = locked_q;
    pcoinc_d   = 1'b0;
    ncoinc_d   = 1'b0;
    dcoinc_d   = 1'b0;
    spwValid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        locked_d = 1'b0;
        if (isIdle) begin
          // An out-of-sequence IDLE restarts the count with itself as the new phase.
          if (cnt_q == 8'd0 || idleIdx == exp_q) cnt_d = cnt_q + 8'd1;
          else                                   cnt_d = 8'd1;
          exp_d = idleIdx + 2'd1;
          if (cnt_d == LOCK_N) begin
            state_d  = RUN;
            locked_d = 1'b1;
            cnt_d    = 8'd0;
          end
        end else begin
          cnt_d = 8'd0;
          exp_d = 2'd0;
        end
      end
      RUN: begin
        if (isIdle) begin
          if (idleIdx == exp_q) exp_d = idleIdx + 2'd1;
          else                  err_d = 1'b1;
        end else begin
          exp_d = 2'd0;
          case (din_q)
            SYM_NCOIN: ncoinc_d = 1'b1;
            SYM_PCOIN: pcoinc_d = 1'b1;
            SYM_DCOIN: dcoinc_d = 1'b1;
            SYM_SPECL: state_d  = SP1;
            default:   err_d    = 1'b1;
          endcase
        end
        if (err_d) begin
          state_d  = HUNT;
          locked_d = 1'b0;
          cnt_d    = 8'd0;
          exp_d    = 2'd0;
        end
      end
      SP1: begin
        shift_d = {shift_q[7:0], din_q};
        state_d = SP2;
      end
      SP2: begin
        shift_d = {shift_q[7:0], din_q};
        state_d = SP3;
      end
      SP3: begin
        shift_d = {shift_q[7:0], din_q};
        state_d = SP4;
      end
      SP4: begin
        spword_d   = {shift_q[11:0], din_q};
        spwValid_d = 1'b1;
        exp_d      = 2'd0;
        state_d    = RUN;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      din_q      <= 4'd0;
      cnt_q      <= 8'd0;
      exp_q      <= 2'd0;
      shift_q    <= 12'd0;
      spword_q   <= 16'd0;
      locked_q   <= 1'b0;
      pcoinc_q   <= 1'b0;
      ncoinc_q   <= 1'b0;
      dcoinc_q   <= 1'b0;
      spwValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      shift_q    <= shift_d;
      spword_q   <= spword_d;
      locked_q   <= locked_d;
      pcoinc_q   <= pcoinc_d;
      ncoinc_q   <= ncoinc_d;
      dcoinc_q   <= dcoinc_d;
      spwValid_q <= spwValid_d;
      err_q      <= err_d;
    end
  end

  assign locked    = locked_q;
  assign pcoinc    = pcoinc_q;
  assign ncoinc    = ncoinc_q;
  assign dcoinc    = dcoinc_q;
  assign spw_valid = spwValid_q;
  assign spword    = spword_q;
  assign err       = err_q;

`ifdef ROCSTAR_RX_STATS_EN
  logic [CNT_W-1:0] nPcoin_q, nNcoin_q, nErr_q;

  // Counters step on the same edge that raises the pulse; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      nPcoin_q <= '0;
      nNcoin_q <= '0;
      nErr_q   <= '0;
    end else begin
      if (pcoinc_d && nPcoin_q != '1) nPcoin_q <= nPcoin_q + CNT_W'(1);
      if (ncoinc_d && nNcoin_q != '1) nNcoin_q <= nNcoin_q + CNT_W'(1);
      if (err_d    && nErr_q   != '1) nErr_q   <= nErr_q   + CNT_W'(1);
    end
  end

  assign n_pcoin = nPcoin_q;
  assign n_ncoin = nNcoin_q;
  assign n_err   = nErr_q;
`else
  logic unusedStatsClr;
  assign unusedStatsClr = stats_clr;
  assign n_pcoin = '0;
  assign n_ncoin = '0;
  assign n_err   = '0;
`endif

endmodule
